// File: rtl/vga_frame_reader.sv
// VGA 640x480@60 scan-out of an RGB332 frame buffer with integer upscaling.
// Counters -> registered RAM address -> RAM data -> registered pins, three clocks end to end.
module vga_frame_reader #(
  parameter int unsigned H_VIS  = 640,
  parameter int unsigned H_FP   = 16,
  parameter int unsigned H_SYNC = 96,
  parameter int unsigned H_BP   = 48,
  parameter int unsigned V_VIS  = 480,
  parameter int unsigned V_FP   = 10,
  parameter int unsigned V_SYNC = 2,
  parameter int unsigned V_BP   = 33,
  parameter int unsigned IMG_W  = 160,
  parameter int unsigned IMG_H  = 120,
  parameter int unsigned SCALE  = 4,
  parameter int unsigned AW     = 15
) (
  input  logic          CLK,
  input  logic          RST,
  output logic [AW-1:0] DP_RAM_addr_out,
  input  logic [7:0]    DP_RAM_data_out,
  output logic [3:0]    VGA_R,
  output logic [3:0]    VGA_G,
  output logic [3:0]    VGA_B,
  output logic          VGA_HS,
  output logic          VGA_VS,
  output logic          frame_end
);

  localparam int unsigned H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int unsigned HW    = $clog2(H_TOT);
  localparam int unsigned VW    = $clog2(V_TOT);
  localparam int unsigned SW    = (SCALE > 1) ? $clog2(SCALE) : 1;

  localparam logic [HW-1:0] HLast  = HW'(H_TOT - 1);
  localparam logic [VW-1:0] VLast  = VW'(V_TOT - 1);
  localparam logic [HW-1:0] HVis   = HW'(H_VIS);
  localparam logic [VW-1:0] VVis   = VW'(V_VIS);
  localparam logic [HW-1:0] HSyncS = HW'(H_VIS + H_FP);
  localparam logic [HW-1:0] HSyncE = HW'(H_VIS + H_FP + H_SYNC);
  localparam logic [VW-1:0] VSyncS = VW'(V_VIS + V_FP);
  localparam logic [VW-1:0] VSyncE = VW'(V_VIS + V_FP + V_SYNC);
  localparam logic [HW-1:0] HImg   = HW'(IMG_W * SCALE);
  localparam logic [VW-1:0] VImg   = VW'(IMG_H * SCALE);
  localparam logic [SW-1:0] SLast  = SW'(SCALE - 1);

  logic [HW-1:0] r_hcnt;
  logic [VW-1:0] r_vcnt;
  logic [SW-1:0] r_sx, r_sy;
  logic [AW-1:0] r_x, r_row;
  logic [1:0]    r_hs_d, r_vs_d, r_on_d, r_fe_d;

  logic w_h_last, w_v_last, w_x_in, w_y_in, w_in_img, w_active;
  logic w_hs_n, w_vs_n, w_fe;
  logic [3:0] w_r4, w_g4, w_b4;

  assign w_h_last = (r_hcnt == HLast);
  assign w_v_last = (r_vcnt == VLast);
  assign w_x_in   = (r_hcnt < HImg);
  assign w_y_in   = (r_vcnt < VImg);
  assign w_in_img = w_x_in && w_y_in;
  assign w_active = (r_hcnt < HVis) && (r_vcnt < VVis);
  assign w_hs_n   = !((r_hcnt >= HSyncS) && (r_hcnt < HSyncE));
  assign w_vs_n   = !((r_vcnt >= VSyncS) && (r_vcnt < VSyncE));
  assign w_fe     = (r_hcnt == '0) && (r_vcnt == VVis);

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_hcnt <= '0;
      r_vcnt <= '0;
    end else begin
      r_hcnt <= w_h_last ? '0 : r_hcnt + HW'(1);
      if (w_h_last) begin
        r_vcnt <= w_v_last ? '0 : r_vcnt + VW'(1);
      end
    end
  end

  // Incremental image coordinates: x steps every SCALE pixels, row_base every SCALE lines.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_sx  <= '0;
      r_x   <= '0;
      r_sy  <= '0;
      r_row <= '0;
    end else begin
      if (w_h_last) begin
        r_sx <= '0;
        r_x  <= '0;
      end else if (w_x_in) begin
        if (r_sx == SLast) begin
          r_sx <= '0;
          r_x  <= r_x + AW'(1);
        end else begin
          r_sx <= r_sx + SW'(1);
        end
      end
      if (w_h_last) begin
        if (w_v_last) begin
          r_sy  <= '0;
          r_row <= '0;
        end else if (w_y_in) begin
          if (r_sy == SLast) begin
            r_sy  <= '0;
            r_row <= r_row + AW'(IMG_W);
          end else begin
            r_sy <= r_sy + SW'(1);
          end
        end
      end
    end
  end

  // Address only moves inside the image, so it never leaves the stored range.
  always_ff @(posedge CLK) begin
    if (RST) begin
      DP_RAM_addr_out <= '0;
    end else if (w_in_img) begin
      DP_RAM_addr_out <= r_row + r_x;
    end
  end

  assign w_r4 = {DP_RAM_data_out[7:5], DP_RAM_data_out[7]};
  assign w_g4 = {DP_RAM_data_out[4:2], DP_RAM_data_out[4]};
  assign w_b4 = {DP_RAM_data_out[1:0], DP_RAM_data_out[1:0]};

  // Two delay stages cover address register + RAM read; syncs reset to their idle (high) level.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_hs_d    <= 2'b11;
      r_vs_d    <= 2'b11;
      r_on_d    <= 2'b00;
      r_fe_d    <= 2'b00;
      VGA_R     <= '0;
      VGA_G     <= '0;
      VGA_B     <= '0;
      VGA_HS    <= 1'b1;
      VGA_VS    <= 1'b1;
      frame_end <= 1'b0;
    end else begin
      r_hs_d    <= {r_hs_d[0], w_hs_n};
      r_vs_d    <= {r_vs_d[0], w_vs_n};
      r_on_d    <= {r_on_d[0], w_active && w_in_img};
      r_fe_d    <= {r_fe_d[0], w_fe};
      VGA_R     <= r_on_d[1] ? w_r4 : 4'h0;
      VGA_G     <= r_on_d[1] ? w_g4 : 4'h0;
      VGA_B     <= r_on_d[1] ? w_b4 : 4'h0;
      VGA_HS    <= r_hs_d[1];
      VGA_VS    <= r_vs_d[1];
      frame_end <= r_fe_d[1];
    end
  end

endmodule

// File: tb/tb_vga_frame_reader.sv
// Randomised bench: two scan-out instances (x4 full image, x2 bordered image) on a shrunk raster,
// each output checked every clock against a cycle-history model of the scan position.
module tb_vga_frame_reader;

  localparam int H_VIS = 64, H_FP = 4, H_SYNC = 8, H_BP = 4;
  localparam int V_VIS = 48, V_FP = 2, V_SYNC = 2, V_BP = 3;
  localparam int IMG_W = 16, IMG_H = 12, AW = 8;
  localparam int HT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int VT = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int FRAME = HT * VT;

  logic          clk, rst;
  logic [AW-1:0] addr0, addr1;
  logic [7:0]    ram0, ram1;
  logic [3:0]    r0, g0, b0, r1, g1, b1;
  logic          hs0, vs0, fe0, hs1, vs1, fe1;
  logic [7:0]    mem [0:255];

  int n_vec, n_err, cyc;
  bit rst_h [0:3];
  int pos_h [0:3];
  int aexp  [0:1];

  vga_frame_reader #(
    .H_VIS(H_VIS), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_VIS(V_VIS), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .IMG_W(IMG_W), .IMG_H(IMG_H), .SCALE(4), .AW(AW)
  ) u_dut_x4 (
    .CLK(clk), .RST(rst), .DP_RAM_addr_out(addr0), .DP_RAM_data_out(ram0),
    .VGA_R(r0), .VGA_G(g0), .VGA_B(b0), .VGA_HS(hs0), .VGA_VS(vs0), .frame_end(fe0)
  );

  vga_frame_reader #(
    .H_VIS(H_VIS), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_VIS(V_VIS), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .IMG_W(IMG_W), .IMG_H(IMG_H), .SCALE(2), .AW(AW)
  ) u_dut_x2 (
    .CLK(clk), .RST(rst), .DP_RAM_addr_out(addr1), .DP_RAM_data_out(ram1),
    .VGA_R(r1), .VGA_G(g1), .VGA_B(b1), .VGA_HS(hs1), .VGA_VS(vs1), .frame_end(fe1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Frame-buffer read port: data one clock after the address.
  always @(posedge clk) ram0 <= mem[addr0];

  function automatic int scl(int d);
    return (d == 0) ? 4 : 2;
  endfunction

  function automatic bit in_img(int p, int s);
    return ((p % HT) < IMG_W * s) && ((p / HT) < IMG_H * s);
  endfunction

  function automatic int img_addr(int p, int s);
    return ((p / HT) / s) * IMG_W + (p % HT) / s;
  endfunction

  function automatic logic [14:0] exp_pins(int p, int d);
    int h, v;
    logic [7:0] px;
    logic [3:0] er, eg, eb;
    logic ehs, evs, efe;
    h   = p % HT;
    v   = p / HT;
    px  = (d == 0) ? mem[img_addr(p, 4)] : 8'hFF;
    ehs = !(h >= H_VIS + H_FP && h < H_VIS + H_FP + H_SYNC);
    evs = !(v >= V_VIS + V_FP && v < V_VIS + V_FP + V_SYNC);
    efe = (h == 0) && (v == V_VIS);
    if (h < H_VIS && v < V_VIS && in_img(p, scl(d))) begin
      er = {px[7:5], px[7]};
      eg = {px[4:2], px[4]};
      eb = {px[1:0], px[1:0]};
    end else begin
      er = 4'h0;
      eg = 4'h0;
      eb = 4'h0;
    end
    return {er, eg, eb, ehs, evs, efe};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %h want %h", tag, cyc, got, want);
    end
  endtask

  // One clock: advance the scan-position history, then compare at the falling edge.
  task automatic step();
    logic [14:0] want;
    @(posedge clk);
    cyc++;
    for (int i = 3; i > 0; i--) begin
      rst_h[i] = rst_h[i-1];
      pos_h[i] = pos_h[i-1];
    end
    rst_h[0] = rst;
    pos_h[0] = rst ? 0 : (pos_h[1] + 1) % FRAME;
    for (int d = 0; d < 2; d++) begin
      if (rst_h[0]) aexp[d] = 0;
      else if (in_img(pos_h[1], scl(d))) aexp[d] = img_addr(pos_h[1], scl(d));
    end
    @(negedge clk);
    check_eq("addr_x4", 32'(addr0), 32'(aexp[0]));
    check_eq("addr_x2", 32'(addr1), 32'(aexp[1]));
    for (int d = 0; d < 2; d++) begin
      if (rst_h[0] || rst_h[1] || rst_h[2]) want = {12'h000, 1'b1, 1'b1, 1'b0};
      else want = exp_pins(pos_h[3], d);
      if (d == 0) check_eq("pins_x4", 32'({r0, g0, b0, hs0, vs0, fe0}), 32'(want));
      else        check_eq("pins_x2", 32'({r1, g1, b1, hs1, vs1, fe1}), 32'(want));
    end
  endtask

  initial begin
    int target;
    n_vec = 0;
    n_err = 0;
    cyc   = 0;
    rst   = 1'b1;
    ram1  = 8'hFF;
    for (int i = 0; i < 4; i++) begin
      rst_h[i] = 1'b1;
      pos_h[i] = 0;
    end
    aexp[0] = 0;
    aexp[1] = 0;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    mem[0] = 8'hE0;
    mem[1] = 8'h1C;
    mem[2] = 8'h03;
    mem[3] = 8'h92;

    repeat (3) step();
    rst = 1'b0;
    repeat (200) step();
    // Reset held 5 clocks in the middle of a line.
    rst = 1'b1;
    repeat (5) step();
    rst = 1'b0;
    repeat (2 * FRAME + 50) step();

    // Single-clock reset deep inside the visible frame.
    target = 30 * HT + 40;
    for (int i = 0; i < FRAME && pos_h[0] != target; i++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (FRAME + 20) step();

    repeat (6) begin
      repeat ($urandom_range(50, 3000)) step();
      rst = 1'b1;
      repeat ($urandom_range(1, 5)) step();
      rst = 1'b0;
    end
    repeat (FRAME) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/vga_frame_reader.md
Name: vga_frame_reader

Overview:
Downstream consumer of the camera capture stage's frame buffer. The capture stage writes RGB332 pixels into a dual-port RAM; this block reads them back through the RAM's read port. It generates 640x480@60 Hz VGA timing from a 25 MHz pixel clock and upscales the stored image by an integer factor. It drives 4-bit-per-channel RGB plus HS/VS to the board DAC, and emits a frame-boundary pulse the capture side can use to avoid tearing.

Parameters:
H_VIS, 640, visible pixels per line
H_FP, 16, horizontal front porch (clocks)
H_SYNC, 96, horizontal sync width (clocks)
H_BP, 48, horizontal back porch (clocks)
V_VIS, 480, visible lines
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
IMG_W, 160, stored image width (pixels)
IMG_H, 120, stored image height (lines)
SCALE, 4, integer upscale factor per axis; IMG_W*SCALE<=H_VIS, IMG_H*SCALE<=V_VIS
AW, 15, RAM address width; 2^AW >= IMG_W*IMG_H

Ports:
CLK  in  1  25 MHz pixel clock, single clock domain
RST  in  1  synchronous, active-high reset
DP_RAM_addr_out  out  AW  read address to frame buffer
DP_RAM_data_out  in  8  read data, RGB332 = {R[2:0],G[2:0],B[1:0]}, valid 1 clock after address
VGA_R  out  4  red
VGA_G  out  4  green
VGA_B  out  4  blue
VGA_HS  out  1  horizontal sync, active low
VGA_VS  out  1  vertical sync, active low
frame_end  out  1  1-clock pulse, start of vertical blanking

Behaviour:
- Counters: hcnt 0..H_TOT-1 (H_TOT=800), vcnt 0..V_TOT-1 (V_TOT=525). hcnt wraps every clock cycle past 799. vcnt increments on hcnt wrap and wraps 524->0.
- Sync (pre-pipeline): hs_n=0 for H_VIS+H_FP <= hcnt < H_VIS+H_FP+H_SYNC (656..751). vs_n=0 for lines 490..491.
- Image region: in_img = hcnt < IMG_W*SCALE && vcnt < IMG_H*SCALE. Image is anchored top-left. Active area outside the image is black.
- Address generation is incremental and uses no multiplier or divider:
  - A sub-pixel counter advances x_img every SCALE clocks.
  - A sub-line counter advances row_base by IMG_W every SCALE lines.
  - addr = row_base + x_img.
  - At hcnt=0: x_img and the sub-pixel counter clear.
  - At vcnt wrap: row_base and the sub-line counter clear.
  - Outside in_img: addr holds its value. It is don't-care but must stay < IMG_W*IMG_H.
- Pipeline, fixed latency 3 clocks from counter value to pins:
  - t: counters.
  - t+1: DP_RAM_addr_out registered.
  - t+2: RAM data valid.
  - t+3: RGB/HS/VS/frame_end registered.
  - hs, vs, in_img and active are delayed so all pins stay mutually aligned.
- Colour expansion:
  - R4={R3,R3[2]}
  - G4={G3,G3[2]}
  - B4={B2,B2}
  - Output 0 whenever the delayed active or in_img is low (blanking or border).
- frame_end: high one clock when the delayed counters equal (hcnt=0, vcnt=V_VIS).
- Reset values: hcnt=vcnt=0, all sub-counters/row_base=0, DP_RAM_addr_out=0, VGA_R/G/B=0, VGA_HS=VGA_VS=1, frame_end=0, pipeline flags cleared.
- Reset mid-frame: all state returns to reset values on the next edge. Counting restarts at (0,0) the clock after RST deasserts. No partial sync pulse may be extended.

Test Plan:
- Reset: hold RST 5 clocks mid-line -> RGB=0, HS=VS=1, addr=0, frame_end=0. The first clock after release corresponds to hcnt=0.
- Line/frame timing: free-run 2 frames -> HS low exactly 96 clocks, period 800. VS low exactly 1600 clocks, period 420000. frame_end period 420000.
- Address sequence: line 0 -> addr 0 for hcnt 0..3, 1 for 4..7, …, 159 for 636..639. Lines 0..3 repeat 0..159. Line 4 starts at 160. Line 479 ends at 19199.
- Latency/colour: RAM model returns data[addr]=addr[7:0] one clock late. 0xE0 -> R=F,G=0,B=0. 0x1C -> G=F. 0x03 -> B=F. 0x92 -> R=9,G=9,B=A. Each appears 3 clocks after its counter value.
- Blanking/border: set SCALE=2 (image 320x240) -> RGB=0 for hcnt>=320 or vcnt>=240 and throughout blanking, while RAM data is 0xFF.
- Reset mid-frame: assert RST at vcnt=300,hcnt=400 for 1 clock -> next frame_end arrives 480*800 clocks after release, and the address sequence restarts at 0.
